// File: rtl/data_mem_responder.sv
// Latency-configurable RV32I data memory responder with a valid/ready request/response handshake.
// Optional DMEM_MISALIGN_TRAP_EN faults misaligned halfword/word accesses instead of aligning them.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        accept;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic          oob, bad_f3, misal, fault, exec;
    logic [31:0]   word_rd, word_sh, ld_data, st_data;
    logic [15:0]   ld_h;
    logic [7:0]    ld_b;
    logic [3:0]    be;

    assign widx    = addr_q[AW+1:2];
    assign lane    = addr_q[1:0];
    assign oob     = |addr_q[31:AW+2];
    assign bad_f3  = we_q ? (f3_q[2] | (&f3_q[1:0]))
                          : ((&f3_q[1:0]) | (f3_q[2] & f3_q[1]));
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal   = ((f3_q[1:0] == 2'b01) & lane[0])
                   | ((f3_q[1:0] == 2'b10) & (lane != 2'b00));
`else
    assign misal   = 1'b0;
`endif
    assign fault   = oob | bad_f3 | misal;
    assign exec    = (state_q == S_WAIT) && (cnt_q == 4'd0);

    assign word_rd = mem[widx];
    assign word_sh = word_rd >> {lane, 3'b000};
    assign ld_b    = word_sh[7:0];
    assign ld_h    = lane[1] ? word_rd[31:16] : word_rd[15:0];

    always_comb begin
        ld_data = 32'd0;
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b010:  ld_data = word_rd;
            3'b100:  ld_data = {24'd0, ld_b};
            3'b101:  ld_data = {16'd0, ld_h};
            default: ld_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        be      = 4'b0000;
        st_data = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                be      = 4'b0001 << lane;
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                be      = 4'b1111;
                st_data = wdata_q;
            end
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && exec && we_q && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    assign accept = (state_q == S_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    rdata_d = (we_q || fault) ? 32'd0 : ld_data;
                    err_d   = fault;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-array memory model plus directed vectors.
// Honours DMEM_MISALIGN_TRAP_EN when the same macro is defined for the build.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mm [0:4*DEPTH-1];
    bit         kn [0:4*DEPTH-1];

    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit bad;
        bit oob;
        bit mis;
        oob = (a >= 32'(4 * DEPTH));
        bad = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
        mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!bad) mis = (a % sz(f3)) != 0;
`endif
        return oob || bad || mis;
    endfunction

    function automatic void m_load(input logic [2:0] f3, input logic [31:0] a,
                                   output logic [31:0] v, output bit known);
        int n;
        int b;
        n = sz(f3);
        b = int'(a) - (int'(a) % n);
        v = 32'd0;
        known = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!kn[b+i]) known = 1'b0;
            v = v | (32'(mm[b+i]) << (8 * i));
        end
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    endfunction

    function automatic void m_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] wd);
        int n;
        int b;
        n = sz(f3);
        b = int'(a) - (int'(a) % n);
        for (int i = 0; i < n; i++) begin
            mm[b+i] = wd[8*i +: 8];
            kn[b+i] = 1'b1;
        end
    endfunction

    bit          pending = 1'b0;
    bit          committed;
    int          acc_cyc;
    bit          p_we;
    logic [2:0]  p_f3;
    logic [31:0] p_a, p_wd, e_rd;
    bit          e_err, e_known;

    // Per-cycle compare: handshake timing and response contents against the model.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", rsp_err, 0);
                pending = 1'b0;
            end else begin
                exp_v = pending && (cyc >= acc_cyc + LAT + 1);
                chk("req_ready", req_ready, !pending);
                chk("rsp_valid", rsp_valid, exp_v);
                if (exp_v) begin
                    if (!committed) begin
                        committed = 1'b1;
                        if (p_we && !e_err) m_store(p_f3, p_a, p_wd);
                    end
                    chk("rsp_err", rsp_err, e_err);
                    if (e_known) chk("rsp_rdata", rsp_rdata, e_rd);
                    if (rsp_ready) pending = 1'b0;
                end else if (!pending && req_valid) begin
                    pending   = 1'b1;
                    committed = 1'b0;
                    acc_cyc   = cyc;
                    p_we      = req_we;
                    p_f3      = req_funct3;
                    p_a       = req_addr;
                    p_wd      = req_wdata;
                    e_err     = m_err(p_we, p_f3, p_a);
                    if (p_we || e_err) begin
                        e_rd    = 32'd0;
                        e_known = 1'b1;
                    end else begin
                        m_load(p_f3, p_a, e_rd, e_known);
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int acc);
        int n;
        @(posedge clk); #1;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_timeout("accept");
        acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_funct3 = 3'b010;
    endtask

    task automatic get(output logic [31:0] rd, output logic er, output int rc);
        int n;
        n = 0;
        @(negedge clk);
        while (!(rsp_valid && rsp_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_timeout("response");
        rd = rsp_rdata;
        er = rsp_err;
        rc = cyc;
    endtask

    task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int acc;
        int rc;
        send(we, f3, a, wd, acc);
        get(rd, er, rc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          acc;
        int          rc;
        int          n;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // SW then LW with latency measurement
        xact(1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err", er, 0);
        send(0, 3'b010, 32'h10, 32'h0, acc);
        get(rd, er, rc);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", er, 0);
        chk("lw_latency", rc - acc, 3);

        xact(0, 3'b000, 32'h13, 0, rd, er); chk("lb", rd, 32'hFFFFFFDE);
        xact(0, 3'b100, 32'h13, 0, rd, er); chk("lbu", rd, 32'h000000DE);
        xact(0, 3'b001, 32'h10, 0, rd, er); chk("lh", rd, 32'hFFFFBEEF);
        xact(0, 3'b101, 32'h12, 0, rd, er); chk("lhu", rd, 32'h0000DEAD);

        xact(1, 3'b000, 32'h11, 32'h000000AA, rd, er);
        xact(0, 3'b010, 32'h10, 0, rd, er); chk("sb_lw", rd, 32'hDEADAAEF);

        xact(0, 3'b010, 32'h400, 0, rd, er);
        chk("oob_err", er, 1); chk("oob_rdata", rd, 0);
        xact(1, 3'b011, 32'h10, 32'h0, rd, er);
        chk("bad_st_err", er, 1);
        xact(0, 3'b010, 32'h10, 0, rd, er); chk("bad_st_nowrite", rd, 32'hDEADAAEF);
        xact(0, 3'b110, 32'h10, 0, rd, er);
        chk("bad_ld_err", er, 1); chk("bad_ld_rdata", rd, 0);

        xact(1, 3'b010, 32'h14, 32'h0, rd, er);
        xact(1, 3'b001, 32'h16, 32'h1234CAFE, rd, er);
        xact(0, 3'b010, 32'h14, 0, rd, er); chk("sh_hi", rd, 32'hCAFE0000);
        xact(0, 3'b001, 32'h16, 0, rd, er); chk("lh_hi", rd, 32'hFFFFCAFE);

        // Response back-pressure; a store offered meanwhile must be ignored
        @(posedge clk); #1 rsp_ready = 1'b0;
        send(0, 3'b010, 32'h10, 0, acc);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_timeout("stall_valid");
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_rdata", rsp_rdata, 32'hDEADAAEF);
            chk("stall_ready", req_ready, 0);
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
            req_addr = 32'h10; req_wdata = 32'h0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        xact(0, 3'b010, 32'h10, 0, rd, er); chk("stall_nowrite", rd, 32'hDEADAAEF);

`ifdef DMEM_MISALIGN_TRAP_EN
        xact(0, 3'b010, 32'h12, 0, rd, er);
        chk("mis_lw_err", er, 1); chk("mis_lw_rdata", rd, 0);
        xact(0, 3'b001, 32'h11, 0, rd, er);
        chk("mis_lh_err", er, 1); chk("mis_lh_rdata", rd, 0);
`else
        xact(0, 3'b010, 32'h12, 0, rd, er);
        chk("mis_lw_err", er, 0); chk("mis_lw_rdata", rd, 32'hDEADAAEF);
        xact(0, 3'b001, 32'h11, 0, rd, er);
        chk("mis_lh_err", er, 0); chk("mis_lh_rdata", rd, 32'hFFFFAAEF);
`endif

        // Reset while the store is still waiting: it must be dropped
        send(1, 3'b010, 32'h20, 32'h12345678, acc);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_valid", rsp_valid, 0);
        xact(0, 3'b010, 32'h20, 0, rd, er);
        checks++;
        if (rd === 32'h12345678) begin
            errors++;
            $display("FAIL rst_store_dropped: got %h expected not 12345678", rd);
        end
        chk("post_rst_err", er, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words; power of two, 16..4096.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: access request present.
REQ-006 SHALL have port req_ready, output, 1: responder can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_funct3, input, 3: RV32I load/store funct3.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, LSB-aligned.
REQ-011 SHALL have port rsp_valid, output, 1: response present.
REQ-012 SHALL have port rsp_ready, input, 1: initiator accepts response.
REQ-013 SHALL have port rsp_rdata, output, 32: load result, extended per funct3.
REQ-014 SHALL have port rsp_err, output, 1: access faulted; valid with rsp_valid.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL accept a request on a cycle with req_valid&&req_ready, register we/funct3/addr/wdata, load the latency counter with LATENCY-1 and enter WAIT.
REQ-018 SHALL decrement the counter each WAIT cycle; the access SHALL execute on the cycle the counter is 0, entering RESP with rsp_valid=1 the next cycle, so rsp_valid rises exactly LATENCY+1 cycles after acceptance.
REQ-019 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_valid&&rsp_ready, then return to IDLE with rsp_valid=0.
REQ-020 SHALL ignore request inputs outside IDLE; next acceptance is no earlier than the cycle after the response handshake.
REQ-021 SHALL store little-endian: word index = addr[log2(DEPTH_WORDS)+1:2], byte lane = addr[1:0].
REQ-022 SHALL return loads as: LB(000) sign-extended byte, LH(001) sign-extended half, LW(010) word, LBU(100) zero-extended byte, LHU(101) zero-extended half.
REQ-023 SHALL store as: SB(000) one lane, SH(001) lanes per addr[1], SW(010) all lanes; other lanes unchanged.
REQ-024 SHALL drive rsp_rdata=0 for stores and for any errored access.
REQ-025 SHALL flag rsp_err=1 with no memory write for an illegal funct3 (loads 011/110/111, stores 011..111) or addr >= 4*DEPTH_WORDS.
REQ-026 SHALL not alter memory contents for loads.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-028 SHALL abandon a request pending in WAIT or RESP on reset; a pending store SHALL NOT be committed.
REQ-029 SHALL NOT initialise memory contents on reset.

Configuration
REQ-030 SHALL, with DMEM_MISALIGN_TRAP_EN defined, flag rsp_err=1 with no write for misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) accesses.
REQ-031 SHALL, without DMEM_MISALIGN_TRAP_EN, ignore addr[0] for halfwords and addr[1:0] for words, treating them as aligned, with rsp_err=0.

Verification
REQ-032 SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after acceptance (LATENCY=2).
REQ-033 SHALL cover: after REQ-032, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
REQ-034 SHALL cover: SB 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF.
REQ-035 SHALL cover: LW 0x400 (DEPTH_WORDS=256) -> rsp_err=1, rsp_rdata=0; store funct3 011 to 0x10 -> rsp_err=1, word at 0x10 unchanged.
REQ-036 SHALL cover: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; LW 0x12 -> rsp_err=1 with DMEM_MISALIGN_TRAP_EN, word at 0x10 without.
REQ-037 SHALL cover: SW 0x20 data 0x12345678 with rst pulsed while in WAIT -> rsp_valid=0, req_ready=1 after reset, LW 0x20 does not return 0x12345678.
